// File: rtl/bf_code_loader.sv
// bf_code_loader
// Writer side of the brainfuck core's code-fetch path. Accepts program text
// over a valid/ready byte stream, writes it into the code RAM from address 0,
// zero-fills the remainder of the RAM and then releases the core from reset.
//
// Parameters:
//   ADDR_W     code address width (matches core addr_code)
//   DEPTH      code RAM depth in bytes, must equal 2**ADDR_W
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   load       single-cycle pulse, starts/restarts a program load
//   in_valid   in_data holds a program byte
//   in_data    program byte (ASCII), 0x00 terminates the program
//   in_ready   combinational, high while loading and load is low
//   wr_en      registered code-RAM write enable
//   wr_addr    registered code-RAM write address
//   wr_data    registered code-RAM write data
//   core_reset registered active-low reset to the core (0 holds it)
//   busy       registered, high during load and zero-fill
//   length     program bytes stored by the last completed load
//   overflow   sticky, last load was truncated at DEPTH-1
//
// Build option:
//   BF_LOADER_FILTER_EN  when defined, only the eight brainfuck characters
//                        and the 0x00 terminator are stored; other bytes are
//                        consumed and dropped.

module bf_code_loader #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              core_reset,
  output logic              busy,
  output logic [ADDR_W-1:0] length,
  output logic              overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic              hs;
  logic              keep;

  assign in_ready = (state == S_LOAD) && !load;
  assign hs       = in_valid && in_ready;

`ifdef BF_LOADER_FILTER_EN
  always_comb begin
    keep = 1'b0;
    case (in_data)
      8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C, 8'h00: keep = 1'b1;
      default: keep = 1'b0;
    endcase
  end
`else
  assign keep = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      addr       <= '0;
      core_reset <= 1'b0;
      busy       <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      length     <= '0;
      overflow   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (load) begin
        state      <= S_LOAD;
        addr       <= '0;
        overflow   <= 1'b0;
        core_reset <= 1'b0;
        busy       <= 1'b1;
      end else begin
        case (state)
          S_LOAD: begin
            // Filtered-out bytes complete the handshake but leave addr alone.
            if (hs && keep) begin
              wr_en   <= 1'b1;
              wr_addr <= addr;
              if (in_data == 8'h00) begin
                wr_data <= '0;
                length  <= addr;
                if (addr == LAST_ADDR) begin
                  state      <= S_RUN;
                  busy       <= 1'b0;
                  core_reset <= 1'b1;
                end else begin
                  addr  <= addr + ADDR_W'(1);
                  state <= S_FILL;
                end
              end else if (addr == LAST_ADDR) begin
                // Last slot is reserved for the terminator: truncate here.
                wr_data    <= '0;
                length     <= LAST_ADDR;
                overflow   <= 1'b1;
                state      <= S_RUN;
                busy       <= 1'b0;
                core_reset <= 1'b1;
              end else begin
                wr_data <= in_data;
                addr    <= addr + ADDR_W'(1);
              end
            end
          end
          S_FILL: begin
            wr_en   <= 1'b1;
            wr_addr <= addr;
            wr_data <= '0;
            if (addr == LAST_ADDR) begin
              state      <= S_RUN;
              busy       <= 1'b0;
              core_reset <= 1'b1;
            end else begin
              addr <= addr + ADDR_W'(1);
            end
          end
          default: begin
            // IDLE and RUN hold until load or reset.
          end
        endcase
      end
    end
  end

endmodule

// File: doc/bf_code_loader.md
Name: bf_code_loader

Overview:
Writer end of the brainfuck core's code-fetch path. It accepts a byte stream of program text over a valid/ready handshake and writes it sequentially into the write port of the code RAM, starting at address 0. It then zero-fills the rest of the RAM and releases the core from reset. The core reads the same RAM through its addr_code/code_out read port and holds it until the next load.

Parameters:
ADDR_W, 9, code address width; matches core addr_code.
DEPTH, 512, code RAM depth in bytes; must equal 2**ADDR_W.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low reset.
load  in  1  single-cycle pulse; starts or restarts a program load.
in_valid  in  1  in_data holds a program byte.
in_data  in  8  program byte (ASCII).
in_ready  out  1  combinational: (state==LOAD) && !load.
wr_en  out  1  registered code-RAM write enable.
wr_addr  out  ADDR_W  registered code-RAM write address.
wr_data  out  8  registered code-RAM write data.
core_reset  out  1  registered active-low reset to the brainfuck core; 0 holds the core.
busy  out  1  registered; 1 in LOAD or FILL.
length  out  ADDR_W  registered; number of program bytes stored by the last completed load.
overflow  out  1  registered; sticky flag, program truncated by the last load.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, addr=0, core_reset=0, busy=0, wr_en=0, wr_addr=0, wr_data=0, length=0, overflow=0.
- States: IDLE (core held, waiting), LOAD, FILL, RUN (core released).
- load in any state: next state LOAD, addr=0, overflow=0, core_reset=0, busy=1, wr_en=0.
  - load has priority over a same-cycle handshake; that byte is not consumed (in_ready=0).
- LOAD: a handshake is in_valid && in_ready at a rising edge. It produces a write on the same edge (wr_en=1, wr_addr=addr, wr_data).
  - The RAM captures the write at the next edge, so latency is 1 cycle from handshake to RAM update.
  - wr_en is 0 in every cycle without a write.
  - Nonzero byte, addr < DEPTH-1: write the byte; addr = addr+1.
  - Byte 0x00 (terminator): write 0x00 at addr; length = addr.
    - If addr == DEPTH-1, go to RUN.
    - Otherwise addr = addr+1 and go to FILL.
  - Nonzero byte with addr == DEPTH-1: write 0x00 instead (forced terminator); length = DEPTH-1; overflow = 1; go to RUN.
- FILL: in_ready=0. Write 0x00 at addr every cycle, then addr = addr+1. The write at DEPTH-1 is the last one; then go to RUN.
  - Fill length is (DEPTH-1-first_fill_addr+1) cycles.
- RUN: core_reset=1, busy=0, wr_en=0, in_ready=0. Stays in RUN until load or reset.
- Consequences:
  - Code RAM always holds a 0x00 at address length.
  - All addresses after length are 0x00.
  - The core never sees stale code.
- Reset asserted mid-LOAD/FILL: immediate return to IDLE with the core held. RAM contents are undefined and a fresh load is required.
- addr never wraps; DEPTH-1 is the last address written.

Optional Feature:
BF_LOADER_FILTER_EN
- Defined: only the eight brainfuck characters '+' '-' '<' '>' '[' ']' '.' ',' and the 0x00 terminator are stored.
  - Any other byte is consumed (handshake completes) but not written; addr does not advance.
  - Filtered bytes never count toward length or overflow.
- Undefined: every nonzero byte is stored verbatim.

Test Plan:
1. Reset low 3 cycles, then high, no load -> core_reset=0, busy=0, in_ready=0, wr_en never 1.
2. load, then stream "+++." then 0x00 -> RAM[0..3]="+++.", RAM[4..511]=0x00. Then length=4, overflow=0, core_reset=1, busy=0.
   - Final fill write at addr 511 is followed by RUN on the next edge.
3. In LOAD, in_valid held high and in_data changed every cycle -> exactly one write per accepted cycle, wr_addr incrementing 0,1,2... Stalling in_valid low for 5 cycles produces no writes and no addr change.
4. Stream 600 '+' bytes without terminator -> RAM[0..510]='+', RAM[511]=0x00. Then length=511, overflow=1, core_reset=1; in_ready=0 for the remaining bytes.
5. Issue load in RUN, then again during FILL of a second load -> core_reset drops to 0 the next cycle, addr restarts at 0, overflow clears. A byte presented in the same cycle as load is not accepted.
6. With BF_LOADER_FILTER_EN defined, stream "a+b-\n" then 0x00 -> RAM[0]='+', RAM[1]='-', RAM[2]=0x00, length=2.
   - Without the macro: RAM[0..4]="a+b-\n", length=5.
